// File: rtl/row_segment_packer.sv
// Packs a stream of row elements into no_of_units-wide, zero-padded segments
// for the row adder, with a row_active frame and a one-cycle gap between rows.
module row_segment_packer #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int len_width     = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [element_width-1:0]             in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [len_width-1:0]                 row_len,
  output logic [no_of_units*element_width-1:0] adder_row_input,
  output logic                                 seg_valid,
  input  logic                                 seg_ready,
  output logic                                 seg_last,
  output logic [len_width-1:0]                 seg_index,
  output logic                                 row_active,
  output logic                                 len_err
);

  localparam int LANE_W = (no_of_units > 1) ? $clog2(no_of_units) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(no_of_units - 1);
  localparam logic [LANE_W-1:0] FIRST_NEXT = (no_of_units > 1) ? LANE_W'(1) : '0;

  typedef enum logic [1:0] {IDLE, FILL, ISSUE, GAP} state_t;

  state_t                               state;
  state_t                               state_nxt;
  logic [len_width-1:0]                 remaining;
  logic [LANE_W-1:0]                    lane;
  logic [no_of_units*element_width-1:0] seg;
  logic [len_width-1:0]                 seg_idx;
  logic                                 active;
  logic                                 err;

  logic accept;
  logic row_start;
  logic zero_len;
  logic fill_done;
  logic handoff;

  assign accept    = in_valid && in_ready;
  assign row_start = (state == IDLE) && accept && (row_len != '0);
  assign zero_len  = (state == IDLE) && accept && (row_len == '0);
  assign handoff   = (state == ISSUE) && seg_ready;

  // A segment completes when its last lane is filled or the row runs out.
  assign fill_done = (row_start && ((row_len == len_width'(1)) || (no_of_units == 1))) ||
                     ((state == FILL) && accept &&
                      ((lane == LAST_LANE) || (remaining == len_width'(1))));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (row_start) state_nxt = fill_done ? ISSUE : FILL;
      FILL:    if (fill_done) state_nxt = ISSUE;
      ISSUE:   if (handoff)   state_nxt = (remaining == '0) ? GAP : FILL;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = !rst && ((state == IDLE) || (state == FILL));
    seg_valid = (state == ISSUE);
    seg_last  = (state == ISSUE) && (remaining == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      lane      <= '0;
      seg       <= '0;
      seg_idx   <= '0;
      active    <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= zero_len;
      if (row_start) begin
        remaining                  <= row_len - len_width'(1);
        seg                        <= '0;
        seg[element_width-1:0]     <= in_data;
        lane                       <= FIRST_NEXT;
        seg_idx                    <= '0;
        active                     <= 1'b1;
      end else if ((state == FILL) && accept) begin
        for (int k = 0; k < no_of_units; k++) begin
          if (lane == LANE_W'(k)) seg[k*element_width +: element_width] <= in_data;
        end
        lane <= lane + LANE_W'(1);
        if (remaining != '0) remaining <= remaining - len_width'(1);
      end
      // Handing a segment off clears it so untouched lanes of the next one read as pad.
      if (handoff) begin
        seg  <= '0;
        lane <= '0;
        if (remaining != '0) seg_idx <= seg_idx + len_width'(1);
        else                 active  <= 1'b0;
      end
      if (state == GAP) seg_idx <= '0;
    end
  end

  assign adder_row_input = seg;
  assign seg_index       = seg_idx;
  assign row_active      = active;
  assign len_err         = err;

endmodule
